cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
MIPS coprocessor-0 block for the multicycle CPU. It holds SR (Status), Cause, EPC and PrID, and raises an interrupt request from the external hardware interrupt lines.
- Sets EXL and captures EPC on interrupt entry.
- Clears EXL on eret.
- Serves mfc0/mtc0 reads and writes selected by rd[1:0]: 0=SR($12), 1=Cause($13), 2=EPC($14), 3=PrID($15).

Parameters:
DEV_CNT, 6, number of hardware interrupt lines (1..6); line i maps to SR.IM/Cause.IP bit 9+i.
PRID_VAL, 32'h0000_0001, constant value returned for PrID.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
PC  input  30  word address PC[31:2] of the instruction to resume after the interrupt
Din  input  32  mtc0 write data (GPR rt value)
HWInt  input  DEV_CNT  external interrupt lines [DEV_CNT:1], level-sensitive, active-high
Sel  input  2  register select (rd[1:0])
Wen  input  1  mtc0 write enable
EXLSet  input  1  interrupt entry: set EXL and capture EPC
EXLClr  input  1  eret: clear EXL
IntReq  output  1  interrupt request to the controller
EPC  output  30  current EPC[31:2], used as the eret target
DOut  output  32  combinational read data for the register chosen by Sel

Behaviour:
- Reset (reset==0 at a clk edge) clears SR, Cause and EPC to 0. IntReq therefore reads 0 after reset. Reset wins over every other input.
- SR layout:
  - IM = bits [9+DEV_CNT:10]
  - EXL = bit 1
  - IE = bit 0
  - all other bits read 0
- Cause layout:
  - IP = bits [9+DEV_CNT:10]
  - all other bits read 0
  - ExcCode [6:2] = 0 (interrupt only)
- EPC register is 30 bits. DOut for EPC is {EPC,2'b00}.
- Cause.IP is registered every cycle: IP <= HWInt, with one-cycle latency.
- IntReq is combinational from registers: IntReq = |(IP & IM) & IE & ~EXL.
- mtc0 (Wen==1), by Sel:
  - Sel=0: SR.IM, SR.EXL, SR.IE are loaded from the corresponding Din bits.
  - Sel=2: EPC <= Din[31:2].
  - Sel=1 and Sel=3: write is ignored (Cause and PrID are read-only).
- EXLSet==1: EXL <= 1 and EPC <= PC. This has priority over a same-cycle mtc0 to SR.EXL or to EPC.
- EXLClr==1: EXL <= 0. This has priority over an mtc0 to SR.EXL.
- EXLSet and EXLClr both high in the same cycle: EXLSet wins.
- While EXL==1, IntReq stays 0 (no nesting), regardless of IP and IM.
- DOut is purely combinational on Sel and current register values. A write lands at the clock edge and is visible on DOut from the next cycle.
- HWInt bits above DEV_CNT do not exist. SR/Cause bits above 9+DEV_CNT read 0.

Optional Feature:
CP0_INT_BYPASS_EN
- Defined: IntReq uses the raw lines, IntReq = |(HWInt & IM) & IE & ~EXL, giving zero-cycle latency. Cause.IP stays registered, so reads still lag by one cycle.
- Undefined: IntReq uses the registered IP as in Behaviour, giving one-cycle latency from HWInt.

Test Plan:
- Reset: hold reset=0 for 2 cycles with HWInt=6'h3F -> DOut=0 for Sel=0, 1 and 2; IntReq=0; EPC=0.
- Interrupt path:
  - Stimulus: mtc0 Sel=0, Din=32'h0000_0401 (IM bit0, IE=1); then HWInt=6'b000001.
  - Next cycle: Cause reads 32'h0000_0400 and IntReq=1.
  - With HWInt=6'b000010 instead: IntReq stays 0.
- Entry and masking: with IntReq=1, pulse EXLSet with PC=30'h0000_0C05 -> EPC=30'h0C05, DOut(Sel=2)=32'h0000_3014, SR reads 32'h0000_0403, IntReq=0 next cycle.
- eret: pulse EXLClr with HWInt still 6'b000001 -> SR reads 32'h0000_0401 and IntReq returns to 1.
- Priority:
  - EXLSet with mtc0 Sel=2, Din=32'h1234_5678 in the same cycle -> EPC=PC.
  - EXLSet and EXLClr together -> EXL=1.
  - mtc0 Sel=1 or Sel=3 -> no change; PrID reads PRID_VAL.
- CP0_INT_BYPASS_EN: build both variants, with IM/IE enabled. Raise HWInt bit0 -> IntReq=1 in the same cycle with the macro, one cycle later without it.

Source files
------------

// File: rtl/cp0_unit_if.sv
// cp0_unit_if: bus between the multicycle controller/datapath and the
// coprocessor-0 block. Signal names match the CP0 port list so the
// controller side reads naturally. HWInt is indexed [DEV_CNT:1] so that
// line i lands on SR.IM/Cause.IP bit 9+i.
interface cp0_unit_if #(
  parameter int DEV_CNT = 6
);
  logic [29:0]        PC;
  logic [31:0]        Din;
  logic [DEV_CNT:1]   HWInt;
  logic [1:0]         Sel;
  logic               Wen;
  logic               EXLSet;
  logic               EXLClr;
  logic               IntReq;
  logic [29:0]        EPC;
  logic [31:0]        DOut;

  modport master (
    output PC, Din, HWInt, Sel, Wen, EXLSet, EXLClr,
    input  IntReq, EPC, DOut
  );

  modport slave (
    input  PC, Din, HWInt, Sel, Wen, EXLSet, EXLClr,
    output IntReq, EPC, DOut
  );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 for the multicycle CPU. Holds SR, Cause,
// EPC and PrID, serves mfc0/mtc0 selected by rd[1:0], and raises IntReq
// from the level-sensitive hardware interrupt lines.
// Optional macro CP0_INT_BYPASS_EN: IntReq is computed from the raw
// HWInt lines (zero-cycle latency) instead of the registered Cause.IP.
module cp0_unit #(
  parameter int          DEV_CNT  = 6,
  parameter logic [31:0] PRID_VAL = 32'h0000_0001
) (
  input  logic       clk,
  input  logic       reset,
  cp0_unit_if.slave  bus
);

  logic [DEV_CNT:1] im_q, im_d;
  logic [DEV_CNT:1] ip_q, ip_d;
  logic             exl_q, exl_d;
  logic             ie_q, ie_d;
  logic [29:0]      epc_q, epc_d;
  logic [31:0]      sr_word;
  logic [31:0]      cause_word;
  logic [DEV_CNT:1] int_src;

  // Next-state: mtc0 first, then eret, then interrupt entry overrides both
  always_comb begin
    im_d  = im_q;
    ie_d  = ie_q;
    exl_d = exl_q;
    epc_d = epc_q;
    ip_d  = bus.HWInt;
    if (bus.Wen && bus.Sel == 2'd0) begin
      im_d  = bus.Din[9+DEV_CNT:10];
      exl_d = bus.Din[1];
      ie_d  = bus.Din[0];
    end
    if (bus.Wen && bus.Sel == 2'd2) begin
      epc_d = bus.Din[31:2];
    end
    if (bus.EXLClr) begin
      exl_d = 1'b0;
    end
    if (bus.EXLSet) begin
      exl_d = 1'b1;
      epc_d = bus.PC;
    end
  end

  // Register update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      im_q  <= '0;
      ip_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      ip_q  <= ip_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      epc_q <= epc_d;
    end
  end

  // Assemble architectural SR and Cause words; unimplemented bits read 0
  always_comb begin
    sr_word               = '0;
    sr_word[9+DEV_CNT:10] = im_q;
    sr_word[1]            = exl_q;
    sr_word[0]            = ie_q;
    cause_word               = '0;
    cause_word[9+DEV_CNT:10] = ip_q;
  end

  // mfc0 read mux, purely combinational on Sel
  always_comb begin
    case (bus.Sel)
      2'd0:    bus.DOut = sr_word;
      2'd1:    bus.DOut = cause_word;
      2'd2:    bus.DOut = {epc_q, 2'b00};
      default: bus.DOut = PRID_VAL;
    endcase
  end

`ifdef CP0_INT_BYPASS_EN
  assign int_src = bus.HWInt;
`else
  assign int_src = ip_q;
`endif

  // Interrupt request, suppressed while EXL is set so handlers do not nest
  assign bus.IntReq = (|(int_src & im_q)) & ie_q & ~exl_q;
  assign bus.EPC    = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: self-checking bench for cp0_unit with a behavioural
// register-level model of CP0 and randomized traffic.
module tb_cp0_unit;
  localparam int DEV_CNT = 6;
  localparam logic [31:0] PRID = 32'h0000_0001;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  cp0_unit_if #(.DEV_CNT(DEV_CNT)) bus ();

  cp0_unit #(.DEV_CNT(DEV_CNT), .PRID_VAL(PRID)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int unsigned m_im, m_ip, m_exl, m_ie, m_epc;

  function automatic int unsigned exp_sr();
    return (m_im << 10) + (m_exl << 1) + m_ie;
  endfunction

  function automatic int unsigned exp_cause();
    return m_ip << 10;
  endfunction

  function automatic int unsigned exp_dout(input int sel);
    case (sel)
      0: return exp_sr();
      1: return exp_cause();
      2: return m_epc * 4;
      default: return PRID;
    endcase
  endfunction

  function automatic logic exp_intreq();
    int unsigned src;
`ifdef CP0_INT_BYPASS_EN
    src = int'(bus.HWInt);
`else
    src = m_ip;
`endif
    return ((src & m_im) != 0) && m_ie == 1 && m_exl == 0;
  endfunction

  // Apply architectural rules for one clock edge using current inputs
  task automatic model_step();
    int unsigned din;
    din = bus.Din;
    if (!reset) begin
      m_im = 0; m_ip = 0; m_exl = 0; m_ie = 0; m_epc = 0;
    end else begin
      if (bus.EXLSet)                         m_exl = 1;
      else if (bus.EXLClr)                    m_exl = 0;
      else if (bus.Wen && bus.Sel == 2'd0)    m_exl = (din >> 1) & 1;
      if (bus.Wen && bus.Sel == 2'd0) begin
        m_im = (din >> 10) & 32'h3F;
        m_ie = din & 1;
      end
      if (bus.EXLSet)                         m_epc = bus.PC;
      else if (bus.Wen && bus.Sel == 2'd2)    m_epc = din >> 2;
      m_ip = int'(bus.HWInt);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.Wen = 1'b0; bus.EXLSet = 1'b0; bus.EXLClr = 1'b0;
    bus.Sel = 2'd0; bus.Din = '0; bus.PC = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    bus.HWInt = 6'h3F;
    bus.Wen = 1'b1; bus.Din = 32'hFFFF_FFFF; bus.EXLSet = 1'b1; bus.PC = 30'h3FFF_FFFF;
    cycle();
    cycle();
    for (int s = 0; s < 3; s++) begin
      bus.Sel = 2'(s);
      #1;
      tests_run++;
      if (bus.DOut !== 32'h0) begin
        $display("[TB] FAIL reset_dout sel=%0d got=%h want=00000000", s, bus.DOut);
        tests_failed++;
      end
    end
    tests_run++;
    if (bus.IntReq !== 1'b0) begin
      $display("[TB] FAIL reset_intreq got=%b want=0", bus.IntReq);
      tests_failed++;
    end
    tests_run++;
    if (bus.EPC !== 30'h0) begin
      $display("[TB] FAIL reset_epc got=%h want=0", bus.EPC);
      tests_failed++;
    end
    idle_inputs();
    bus.HWInt = '0;
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_interrupt();
    bus.Wen = 1'b1; bus.Sel = 2'd0; bus.Din = 32'h0000_0401;
    cycle();
    bus.Wen = 1'b0;
    bus.HWInt = 6'b000001;
    cycle();
    bus.Sel = 2'd1;
    #1;
    tests_run++;
    if (bus.DOut !== 32'h0000_0400) begin
      $display("[TB] FAIL int_cause got=%h want=00000400", bus.DOut);
      tests_failed++;
    end
    tests_run++;
    if (bus.IntReq !== 1'b1) begin
      $display("[TB] FAIL int_req got=%b want=1", bus.IntReq);
      tests_failed++;
    end
    bus.HWInt = 6'b000010;
    cycle();
    tests_run++;
    if (bus.IntReq !== 1'b0) begin
      $display("[TB] FAIL int_masked got=%b want=0", bus.IntReq);
      tests_failed++;
    end
    tests_run++;
    if (bus.DOut !== 32'h0000_0800) begin
      $display("[TB] FAIL int_cause2 got=%h want=00000800", bus.DOut);
      tests_failed++;
    end
  endtask

  task automatic test_entry();
    bus.HWInt = 6'b000001;
    cycle();
    tests_run++;
    if (bus.IntReq !== 1'b1) begin
      $display("[TB] FAIL entry_pre_req got=%b want=1", bus.IntReq);
      tests_failed++;
    end
    bus.EXLSet = 1'b1; bus.PC = 30'h0000_0C05;
    cycle();
    bus.EXLSet = 1'b0;
    bus.Sel = 2'd2;
    #1;
    tests_run++;
    if (bus.EPC !== 30'h0000_0C05) begin
      $display("[TB] FAIL entry_epc got=%h want=00000c05", bus.EPC);
      tests_failed++;
    end
    tests_run++;
    if (bus.DOut !== 32'h0000_3014) begin
      $display("[TB] FAIL entry_epc_read got=%h want=00003014", bus.DOut);
      tests_failed++;
    end
    bus.Sel = 2'd0;
    #1;
    tests_run++;
    if (bus.DOut !== 32'h0000_0403) begin
      $display("[TB] FAIL entry_sr got=%h want=00000403", bus.DOut);
      tests_failed++;
    end
    tests_run++;
    if (bus.IntReq !== 1'b0) begin
      $display("[TB] FAIL entry_masked got=%b want=0", bus.IntReq);
      tests_failed++;
    end
  endtask

  task automatic test_eret();
    bus.EXLClr = 1'b1;
    cycle();
    bus.EXLClr = 1'b0;
    bus.Sel = 2'd0;
    #1;
    tests_run++;
    if (bus.DOut !== 32'h0000_0401) begin
      $display("[TB] FAIL eret_sr got=%h want=00000401", bus.DOut);
      tests_failed++;
    end
    tests_run++;
    if (bus.IntReq !== 1'b1) begin
      $display("[TB] FAIL eret_req got=%b want=1", bus.IntReq);
      tests_failed++;
    end
  endtask

  task automatic test_priority();
    logic [29:0] pc_val;
    logic [31:0] din_val;
    pc_val = 30'($urandom);
    bus.PC = pc_val; bus.EXLSet = 1'b1;
    bus.Wen = 1'b1; bus.Sel = 2'd2; bus.Din = 32'h1234_5678;
    cycle();
    tests_run++;
    if (bus.EPC !== pc_val) begin
      $display("[TB] FAIL prio_epc got=%h want=%h", bus.EPC, pc_val);
      tests_failed++;
    end
    bus.Wen = 1'b0; bus.EXLSet = 1'b1; bus.EXLClr = 1'b1;
    cycle();
    bus.EXLSet = 1'b0; bus.EXLClr = 1'b0; bus.Sel = 2'd0;
    #1;
    tests_run++;
    if (bus.DOut !== 32'h0000_0403) begin
      $display("[TB] FAIL prio_set_clr got=%h want=00000403", bus.DOut);
      tests_failed++;
    end
    bus.EXLClr = 1'b1; bus.Wen = 1'b1; bus.Sel = 2'd0; bus.Din = 32'h0000_0403;
    cycle();
    bus.EXLClr = 1'b0; bus.Wen = 1'b0;
    tests_run++;
    if (bus.DOut !== 32'h0000_0401) begin
      $display("[TB] FAIL prio_clr_mtc0 got=%h want=00000401", bus.DOut);
      tests_failed++;
    end
    for (int s = 1; s <= 3; s += 2) begin
      din_val = $urandom;
      bus.Wen = 1'b1; bus.Sel = 2'(s); bus.Din = din_val;
      cycle();
      bus.Wen = 1'b0;
      bus.Sel = 2'd0;
      #1;
      tests_run++;
      if (bus.DOut !== 32'h0000_0401 || bus.EPC !== pc_val) begin
        $display("[TB] FAIL ro_write sel=%0d sr=%h epc=%h want sr=00000401 epc=%h", s, bus.DOut, bus.EPC, pc_val);
        tests_failed++;
      end
    end
    bus.Sel = 2'd3;
    #1;
    tests_run++;
    if (bus.DOut !== PRID) begin
      $display("[TB] FAIL prid got=%h want=%h", bus.DOut, PRID);
      tests_failed++;
    end
    bus.Sel = 2'd1;
    #1;
    tests_run++;
    if (bus.DOut !== 32'h0000_0400) begin
      $display("[TB] FAIL ro_cause got=%h want=00000400", bus.DOut);
      tests_failed++;
    end
  endtask

  task automatic test_latency();
    logic want_now;
    bus.HWInt = '0;
    cycle();
    tests_run++;
    if (bus.IntReq !== 1'b0) begin
      $display("[TB] FAIL lat_idle got=%b want=0", bus.IntReq);
      tests_failed++;
    end
    bus.HWInt = 6'b000001;
    #1;
`ifdef CP0_INT_BYPASS_EN
    want_now = 1'b1;
`else
    want_now = 1'b0;
`endif
    tests_run++;
    if (bus.IntReq !== want_now) begin
      $display("[TB] FAIL lat_same_cycle got=%b want=%b", bus.IntReq, want_now);
      tests_failed++;
    end
    cycle();
    tests_run++;
    if (bus.IntReq !== 1'b1) begin
      $display("[TB] FAIL lat_next_cycle got=%b want=1", bus.IntReq);
      tests_failed++;
    end
  endtask

  task automatic test_random();
    int unsigned want;
    for (int i = 0; i < 300; i++) begin
      reset      = ($urandom_range(0, 39) != 0);
      bus.HWInt  = 6'($urandom);
      bus.Sel    = 2'($urandom);
      bus.Wen    = ($urandom_range(0, 2) == 0);
      bus.Din    = $urandom;
      bus.PC     = 30'($urandom);
      bus.EXLSet = ($urandom_range(0, 7) == 0);
      bus.EXLClr = ($urandom_range(0, 5) == 0);
      cycle();
      want = exp_dout(int'(bus.Sel));
      tests_run++;
      if (bus.DOut !== want || bus.IntReq !== exp_intreq() || bus.EPC !== 30'(m_epc)) begin
        $display("[TB] FAIL rand_%0d sel=%0d dout=%h/%h intreq=%b/%b epc=%h/%h", i, bus.Sel,
                 bus.DOut, want, bus.IntReq, exp_intreq(), bus.EPC, 30'(m_epc));
        tests_failed++;
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    m_im = 0; m_ip = 0; m_exl = 0; m_ie = 0; m_epc = 0;
    reset = 1'b0;
    bus.HWInt = '0;
    idle_inputs();
    test_reset();
    test_interrupt();
    test_entry();
    test_eret();
    test_priority();
    test_latency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
